race_sequencer: RTL
===================

RACE_SEQUENCER -- requirements
Module: race_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50_000, Clock cycles per millisecond tick (50 MHz).
REQ-002 Parameter MAX_MS, default 16'd9_999, race timeout in ms; ET counters saturate here.
REQ-003 Clock  input  1  50 MHz system clock; all state updates on posedge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  single-cycle request to begin a race.
REQ-006 Stage1, Stage2  input  1 each  lane staged beam blocked (level).
REQ-007 Launch1, Launch2  input  1 each  lane car has left the start beam (level, held once set).
REQ-008 Finish1, Finish2  input  1 each  lane finish beam crossed (single-cycle pulse).
REQ-009 G  input  1  green-light output of the light-tree timer.
REQ-010 En  output  1  enable to the light-tree timer.
REQ-011 R  output  1  red-light signal to the light-tree timer; OR of Red1 and Red2.
REQ-012 Red1, Red2  output  1 each  lane foul (red light) latched.
REQ-013 ET1, ET2  output  16 each  lane elapsed time in ms from G rising.
REQ-014 Winner  output  2  0 none, 1 lane 1, 2 lane 2, 3 tie.
REQ-015 Done  output  1  results valid and held.
REQ-016 State  output  2  IDLE=0, TREE=1, RACE=2, DONE=3.

Function
REQ-017 IDLE: En=0. Start while Stage1&Stage2 moves to TREE next cycle. Start otherwise is ignored.
REQ-018 TREE: En=1. Launch asserted on a lane while G=0 sets that lane's Red the same cycle; Red stays latched until IDLE.
REQ-019 TREE: G rising moves to RACE and clears the ms prescaler and ET1/ET2 to 0. Both Red set before G moves directly to DONE with Winner=0.
REQ-020 RACE: En=1. Prescaler counts 0..TICK_DIV-1. On wrap, each unfinished lane's ET increments by 1, saturating at MAX_MS.
REQ-021 RACE: Finish pulse freezes that lane's ET. Finish on a Red lane freezes ET but the lane is excluded from Winner.
REQ-022 Winner goes to the first non-Red lane to finish. If both non-Red lanes finish in the same cycle, Winner=3. A later finish never changes Winner.
REQ-023 RACE moves to DONE when every non-Red lane has finished, or when any unfinished ET reaches MAX_MS.
REQ-024 On timeout, an unfinished lane's ET reads MAX_MS. If no non-Red lane finished, Winner=0.
REQ-025 DONE: En=0, Done=1; ET, Winner and Red hold. Start moves to IDLE and clears the results.
REQ-026 Finish pulses outside RACE are ignored. Launch outside TREE does not set Red.
REQ-027 A Launch in the same cycle as G rising is legal and does not set Red.
REQ-028 A lane that unstages (Stage low) in TREE without Launch is not fouled. Staging is sampled only at Start in IDLE.

Reset
REQ-029 Reset has priority over all inputs. Next cycle: State=IDLE, En=0, R=0, Red1=Red2=0, ET1=ET2=0, Winner=0, Done=0, prescaler=0.
REQ-030 Reset asserted mid-TREE or mid-RACE aborts the race, discards all partial results and drops En to 0 the following cycle.

Verification (TICK_DIV=4, MAX_MS=20)
REQ-031 Both staged, Start, G rises, Finish1 at 10 ticks, Finish2 at 12 ticks -> ET1=10, ET2=12, Winner=1, Done=1.
REQ-032 Launch2 during TREE before G -> Red2=1 and R=1 immediately. Lane 2 finishes first -> Winner=1.
REQ-033 Launch1 and Launch2 both before G -> DONE with Winner=0, Red1=Red2=1, and no RACE state visited.
REQ-034 Finish1 and Finish2 in the same cycle at 8 ticks -> ET1=ET2=8, Winner=3.
REQ-035 Only lane 1 finishes, lane 2 never does -> DONE when ET2=20, Winner=1, ET2=20.
REQ-036 Reset mid-RACE at ET=5 -> all outputs are at reset values the next cycle. Start with only Stage1 set -> State stays IDLE.

Source files
------------

// File: rtl/race_sequencer.sv
// Drag-race sequencer: stages the light tree, detects fouls, times both lanes in
// millisecond ticks and reports the winner.
module race_sequencer #(
  parameter int          TICK_DIV = 50_000,
  parameter logic [15:0] MAX_MS   = 16'd9_999
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stage1_i,
  input  logic        stage2_i,
  input  logic        launch1_i,
  input  logic        launch2_i,
  input  logic        finish1_i,
  input  logic        finish2_i,
  input  logic        g_i,
  output logic        en_o,
  output logic        r_o,
  output logic        red1_o,
  output logic        red2_o,
  output logic [15:0] et1_o,
  output logic [15:0] et2_o,
  output logic [1:0]  winner_o,
  output logic        done_o,
  output logic [1:0]  state_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TREE = 2'd1, S_RACE = 2'd2, S_DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic            g_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     et1_q, et1_d, et2_q, et2_d;
  logic            fin1_q, fin1_d, fin2_q, fin2_d;
  logic            red1_q, red1_d, red2_q, red2_d;
  logic [1:0]      winner_q, winner_d;

  logic in_tree, in_race, g_rise, foul1, foul2, tick;
  logic fin1_evt, fin2_evt, win1, win2, race_over;

  assign in_tree  = (state_q == S_TREE);
  assign in_race  = (state_q == S_RACE);
  assign g_rise   = g_i & ~g_q;
  // A launch counts as a foul only while the green is still off.
  assign foul1    = in_tree & launch1_i & ~g_i;
  assign foul2    = in_tree & launch2_i & ~g_i;
  assign tick     = in_race & (presc_q == PRESC_TOP);
  assign fin1_evt = in_race & finish1_i & ~fin1_q;
  assign fin2_evt = in_race & finish2_i & ~fin2_q;
  assign win1     = fin1_evt & ~red1_q;
  assign win2     = fin2_evt & ~red2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      g_q      <= 1'b0;
      presc_q  <= '0;
      et1_q    <= '0;
      et2_q    <= '0;
      fin1_q   <= 1'b0;
      fin2_q   <= 1'b0;
      red1_q   <= 1'b0;
      red2_q   <= 1'b0;
      winner_q <= 2'd0;
    end else begin
      g_q      <= g_i;
      presc_q  <= presc_d;
      et1_q    <= et1_d;
      et2_q    <= et2_d;
      fin1_q   <= fin1_d;
      fin2_q   <= fin2_d;
      red1_q   <= red1_d;
      red2_q   <= red2_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    presc_d  = presc_q;
    et1_d    = et1_q;
    et2_d    = et2_q;
    fin1_d   = fin1_q;
    fin2_d   = fin2_q;
    red1_d   = red1_q;
    red2_d   = red2_q;
    winner_d = winner_q;
    case (state_q)
      S_TREE: begin
        red1_d = red1_q | foul1;
        red2_d = red2_q | foul2;
        if (g_rise) begin
          presc_d  = '0;
          et1_d    = '0;
          et2_d    = '0;
          fin1_d   = 1'b0;
          fin2_d   = 1'b0;
          winner_d = 2'd0;
        end
      end
      S_RACE: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        // A finish on the wrap cycle freezes the lane before the increment.
        if (fin1_evt)                             fin1_d = 1'b1;
        else if (tick && !fin1_q && et1_q != MAX_MS) et1_d = et1_q + 16'd1;
        if (fin2_evt)                             fin2_d = 1'b1;
        else if (tick && !fin2_q && et2_q != MAX_MS) et2_d = et2_q + 16'd1;
        if (winner_q == 2'd0) winner_d = {win2, win1};
      end
      S_DONE: begin
        if (start_i) begin
          presc_d  = '0;
          et1_d    = '0;
          et2_d    = '0;
          fin1_d   = 1'b0;
          fin2_d   = 1'b0;
          red1_d   = 1'b0;
          red2_d   = 1'b0;
          winner_d = 2'd0;
        end
      end
      default: ;
    endcase
  end

  assign race_over = ((fin1_d | red1_q) & (fin2_d | red2_q))
                   | (~fin1_d & (et1_d == MAX_MS))
                   | (~fin2_d & (et2_d == MAX_MS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i && stage1_i && stage2_i) state_d = S_TREE;
      S_TREE: begin
        if (red1_d && red2_d) state_d = S_DONE;
        else if (g_rise)      state_d = S_RACE;
      end
      S_RACE: if (race_over) state_d = S_DONE;
      S_DONE: if (start_i)   state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    en_o     = in_tree | in_race;
    done_o   = (state_q == S_DONE);
    red1_o   = red1_q | foul1;
    red2_o   = red2_q | foul2;
    r_o      = red1_o | red2_o;
    et1_o    = et1_q;
    et2_o    = et2_q;
    winner_o = winner_q;
    state_o  = state_q;
  end

endmodule
